// File: rtl/square_calc_pkg.sv
// -----------------------------------------------------------------------------
// square_calc_pkg
// Shared definitions for the iterative fixed-point squarer (square_calc).
//   - state_t      : controller states (IDLE, CALC, DONE)
//   - W, PROD_W    : operand width (Q4.8 -> 12 bits) and product width (Q8.16)
//   - frac_to_int(): reduces a Q8.16 product to its 8-bit integer part
// Optional build macro: SQUARE_CALC_ROUND_EN
//   defined   -> frac_to_int rounds half-up on the first fraction bit and
//                saturates at all-ones
//   undefined -> frac_to_int truncates (no rounding adder exists)
// -----------------------------------------------------------------------------
package square_calc_pkg;

  localparam int SQ_W_INT  = 4;
  localparam int SQ_W_FRAC = 8;
  localparam int W         = SQ_W_INT + SQ_W_FRAC;
  localparam int PROD_W    = 2 * W;
  localparam int INT_W     = 2 * SQ_W_INT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [INT_W-1:0] frac_to_int(input logic [PROD_W-1:0] prod);
`ifdef SQUARE_CALC_ROUND_EN
    logic [INT_W:0] sum;
    // Half-up rounding: add the MSB of the fraction field; a carry out of the
    // integer field means the rounded value no longer fits, so clamp.
    sum = {1'b0, prod[PROD_W-1:2*SQ_W_FRAC]} + {{INT_W{1'b0}}, prod[2*SQ_W_FRAC-1]};
    return sum[INT_W] ? {INT_W{1'b1}} : sum[INT_W-1:0];
`else
    return prod[PROD_W-1:2*SQ_W_FRAC];
`endif
  endfunction

endpackage

// File: rtl/square_calc_dp.sv
// -----------------------------------------------------------------------------
// square_calc_dp
// Shift-add datapath of the squarer: one multiplier bit per clock.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   load   in   capture operand, clear accumulator and bit counter
//   step   in   process multiplier bit [counter], advance counter
//   in     in   operand (OPW bits)
//   last   out  counter is on the final bit (OPW-1)
//   acc    out  running product (2*OPW bits)
// -----------------------------------------------------------------------------
module square_calc_dp
  import square_calc_pkg::*;
#(
  parameter int OPW = W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [OPW-1:0]   in,
  output logic             last,
  output logic [2*OPW-1:0] acc
);

  localparam int CNT_W = $clog2(OPW);

  // Multiplicand and multiplier are the same value when squaring, so a single
  // operand register serves as both.
  logic [OPW-1:0]   opnd_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2*OPW-1:0] acc_reg;
  logic [2*OPW-1:0] partial;

  assign partial = {{OPW{1'b0}}, opnd_reg} << cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd_reg <= '0;
      cnt_reg  <= '0;
      acc_reg  <= '0;
    end else if (load) begin
      opnd_reg <= in;
      cnt_reg  <= '0;
      acc_reg  <= '0;
    end else if (step) begin
      // Sum of all partials is opnd^2 < 2^(2*OPW): the add cannot overflow.
      if (opnd_reg[cnt_reg]) begin
        acc_reg <= acc_reg + partial;
      end
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign last = (cnt_reg == CNT_W'(OPW - 1));
  assign acc  = acc_reg;

endmodule

// File: rtl/square_calc.sv
// -----------------------------------------------------------------------------
// square_calc
// Iterative squarer for Q4.8 roots (low 12 bits of a 16-bit container).
// Produces the Q8.16 square and its 8-bit integer part with a
// start/busy/done handshake; one operand bit is processed per clock.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   square request, honoured only in IDLE or DONE
//   in       in   16-bit container, Q4.8 root in in[11:0]
//   busy     out  registered: high for the 12 cycles following acceptance
//   done     out  one-cycle pulse, out_prod/out_int valid from this cycle
//   out_prod out  Q8.16 square, held until the next done
//   out_int  out  integer part of the square
// Build macro: SQUARE_CALC_ROUND_EN selects rounded (saturating) out_int
// instead of truncated; see square_calc_pkg::frac_to_int.
// -----------------------------------------------------------------------------
module square_calc
  import square_calc_pkg::*;
#(
  parameter int W_INT  = SQ_W_INT,
  parameter int W_FRAC = SQ_W_FRAC
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [15:0]                in,
  output logic                       busy,
  output logic                       done,
  output logic [2*(W_INT+W_FRAC)-1:0] out_prod,
  output logic [2*W_INT-1:0]          out_int
);

  localparam int OPW = W_INT + W_FRAC;

  state_t           state_reg;
  state_t           state_next;
  logic             load;
  logic             step;
  logic             last;
  logic [2*OPW-1:0] acc;

  square_calc_dp #(
    .OPW (OPW)
  ) u_dp (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .step  (step),
    .in    (in[OPW-1:0]),
    .last  (last),
    .acc   (acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // A start here restarts straight into CALC, skipping IDLE.
        if (start) begin
          load       = 1'b1;
          state_next = CALC;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the current state, so they trail the state
  // by one clock. Results are published together with the done pulse, after
  // busy has already dropped, which keeps them stable for the whole busy window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      out_prod <= '0;
      out_int  <= '0;
    end else begin
      busy <= (state_reg == CALC);
      done <= (state_reg == DONE);
      if (state_reg == DONE) begin
        out_prod <= acc;
        out_int  <= frac_to_int(acc);
      end
    end
  end

endmodule

// File: tb/tb_square_calc.sv
// -----------------------------------------------------------------------------
// tb_square_calc
// Directed testbench for square_calc with hand-computed expected squares.
// Honours SQUARE_CALC_ROUND_EN for the expected integer parts.
// -----------------------------------------------------------------------------
module tb_square_calc;
  import square_calc_pkg::*;

`ifdef SQUARE_CALC_ROUND_EN
  localparam logic [7:0] EXP_INT_2D4 = 8'h08;
`else
  localparam logic [7:0] EXP_INT_2D4 = 8'h07;
`endif

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b1;
  logic        start  = 1'b0;
  logic [15:0] in_val = 16'h0000;
  logic        busy;
  logic        done;
  logic [23:0] out_prod;
  logic [7:0]  out_int;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  square_calc dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in       (in_val),
    .busy     (busy),
    .done     (done),
    .out_prod (out_prod),
    .out_int  (out_int)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // mode 0: single operation
  // mode 1: extra start pulses 4 and 9 cycles into the operation, input changed
  // mode 2: start held in the DONE-state cycle with in=0x0200 (back-to-back)
  task automatic run_op(input string tag, input logic [15:0] v, input int mode,
                        input logic [23:0] exp_prod, input logic [7:0] exp_int);
    logic [23:0] prev;
    logic [23:0] first_prod;
    int          ndone;
    int          nbusy;
    int          first;
    int          unstable;
    int          limit;
    prev       = out_prod;
    first_prod = '0;
    ndone      = 0;
    nbusy      = 0;
    first      = 0;
    unstable   = 0;
    limit      = (mode == 2) ? 30 : 20;
    @(negedge clk);
    in_val = v;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    in_val = 16'h0ABC;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (first == 0) begin
          first      = k;
          first_prod = out_prod;
        end
        prev = out_prod;
      end
      if (busy) begin
        nbusy++;
        if (out_prod !== prev) unstable++;
      end
      start = 1'b0;
      if (mode == 1 && (k == 4 || k == 9)) start = 1'b1;
      if (mode == 2 && k == 12) begin
        start  = 1'b1;
        in_val = 16'h0200;
      end
    end
    start = 1'b0;
    check({tag, " done_latency"}, first, 13);
    check({tag, " busy_cycles"}, nbusy, (mode == 2) ? 24 : 12);
    check({tag, " done_pulses"}, ndone, (mode == 2) ? 2 : 1);
    check({tag, " stable_while_busy"}, unstable, 0);
    if (mode == 2) check({tag, " first_prod"}, first_prod, 24'h010000);
    check({tag, " out_prod"}, out_prod, exp_prod);
    check({tag, " out_int"}, out_int, exp_int);
    $display("op %s in=0x%04h mode=%0d prod=0x%06h int=0x%02h done_at=%0d",
             tag, v, mode, out_prod, out_int, first);
  endtask

  initial begin
    int ndone;
    int nbusy;

    // Reset then idle
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst busy", busy, 1'b0);
      check("rst done", done, 1'b0);
      check("rst prod", out_prod, 24'h0);
      check("rst int", out_int, 8'h0);
    end
    rst_n = 1'b1;
    ndone = 0;
    nbusy = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done) ndone++;
      if (busy) nbusy++;
    end
    check("idle done", ndone, 0);
    check("idle busy", nbusy, 0);
    check("idle prod", out_prod, 24'h0);
    $display("op reset_idle prod=0x%06h int=0x%02h", out_prod, out_int);

    // Package reduction function against hand values
    check("f2i 07FF90", frac_to_int(24'h07FF90), EXP_INT_2D4);
    check("f2i FFE001", frac_to_int(24'hFFE001), 8'hFF);

    run_op("one",  16'h0100, 0, 24'h010000, 8'h01);
    run_op("2d4",  16'h02D4, 1, 24'h07FF90, EXP_INT_2D4);
    run_op("ffff", 16'hFFFF, 0, 24'hFFE001, 8'hFF);
    run_op("zero", 16'h0000, 0, 24'h000000, 8'h00);
    run_op("b2b",  16'h0100, 2, 24'h040000, 8'h04);

    // Reset mid-operation
    @(negedge clk);
    in_val = 16'h0300;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midrst busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst prod", out_prod, 24'h0);
    check("midrst int", out_int, 8'h0);
    check("midrst busy", busy, 1'b0);
    check("midrst done", done, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst no_done", ndone, 0);
    $display("op mid_reset in=0x0300 prod=0x%06h done_pulses=%0d", out_prod, ndone);

    run_op("after_rst", 16'h0300, 0, 24'h090000, 8'h09);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
